// File: rtl/jump_target_if.sv
// Handshake bundle between decode and the jump target unit.
// Decode (master) presents requests and accepts results; the unit is the slave.
interface jump_target_if #(
  parameter int ADDR_W    = 32,
  parameter int IDX_W     = 26,
  parameter int RAS_DEPTH = 4
) ();
  localparam int CNT_W = $clog2(RAS_DEPTH) + 1;

  logic              in_valid;
  logic              in_ready;
  logic [1:0]        op;
  logic [ADDR_W-1:0] pc_plus4;
  logic [IDX_W-1:0]  imm;
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] target;
  logic              out_err;
  logic [CNT_W-1:0]  ras_count;

  modport master (
    output in_valid, op, pc_plus4, imm, out_ready,
    input  in_ready, out_valid, target, out_err, ras_count
  );

  modport slave (
    input  in_valid, op, pc_plus4, imm, out_ready,
    output in_ready, out_valid, target, out_err, ras_count
  );
endinterface

// File: rtl/jump_target_unit.sv
// Pipelined next-PC target generator: JUMP, BRANCH, CALL and RETURN targets
// registered behind a valid/ready handshake with one cycle of latency.
// Optional return-address stack enabled by defining JUMP_TARGET_RAS_EN; with it
// undefined CALL acts as JUMP and RETURN falls through to pc_plus4 with out_err.
module jump_target_unit #(
  parameter int ADDR_W    = 32,
  parameter int IDX_W     = 26,
  parameter int OFF_W     = 16,
  parameter int SHIFT     = 2,
  parameter int RAS_DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  jump_target_if.slave bus
);

  localparam int CNT_W = $clog2(RAS_DEPTH) + 1;
  localparam int PTR_W = $clog2(RAS_DEPTH);

  localparam logic [1:0] OP_JUMP   = 2'b00;
  localparam logic [1:0] OP_BRANCH = 2'b01;
  localparam logic [1:0] OP_CALL   = 2'b10;
  localparam logic [1:0] OP_RETURN = 2'b11;

  // Bits below this mask come from the shifted index; the rest keep pc_plus4.
  // When the shifted index fills the whole address the mask is all ones.
  localparam logic [ADDR_W-1:0] LOW_MASK =
    (ADDR_W'(1) << (IDX_W + SHIFT)) - ADDR_W'(1);

  logic              valid_q, valid_d;
  logic [ADDR_W-1:0] target_q, target_d;
  logic              err_q, err_d;

  logic                    accept_s;
  logic [ADDR_W-1:0]       jump_s;
  logic signed [OFF_W-1:0] off_s;
  logic [ADDR_W-1:0]       br_off_s;
  logic [ADDR_W-1:0]       branch_s;

`ifdef JUMP_TARGET_RAS_EN
  logic [ADDR_W-1:0] ras_q [RAS_DEPTH];
  logic [PTR_W-1:0]  wp_q, wp_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              push_s;
`endif

  assign bus.in_ready  = !valid_q || bus.out_ready;
  assign accept_s      = bus.in_valid && bus.in_ready;
  assign bus.out_valid = valid_q;
  assign bus.target    = target_q;
  assign bus.out_err   = err_q;

  assign jump_s   = (bus.pc_plus4 & ~LOW_MASK) | (ADDR_W'(bus.imm) << SHIFT);
  assign off_s    = $signed(bus.imm[OFF_W-1:0]);
  assign br_off_s = ADDR_W'(off_s) << SHIFT;
  assign branch_s = bus.pc_plus4 + br_off_s;

`ifdef JUMP_TARGET_RAS_EN
  assign bus.ras_count = count_q;
`else
  assign bus.ras_count = {CNT_W{1'b0}};
`endif

  // Next-state for the result register, handshake and stack pointers.
  always_comb begin
    valid_d  = valid_q;
    target_d = target_q;
    err_d    = err_q;
`ifdef JUMP_TARGET_RAS_EN
    wp_d     = wp_q;
    count_d  = count_q;
    push_s   = 1'b0;
`endif
    if (accept_s) begin
      valid_d = 1'b1;
      case (bus.op)
        OP_JUMP: begin
          target_d = jump_s;
          err_d    = 1'b0;
        end
        OP_BRANCH: begin
          target_d = branch_s;
          err_d    = 1'b0;
        end
        OP_CALL: begin
          target_d = jump_s;
          err_d    = 1'b0;
`ifdef JUMP_TARGET_RAS_EN
          // Circular push: when full the oldest entry is overwritten.
          push_s = 1'b1;
          wp_d   = wp_q + PTR_W'(1);
          if (count_q == CNT_W'(RAS_DEPTH)) begin
            count_d = count_q;
          end else begin
            count_d = count_q + CNT_W'(1);
          end
`endif
        end
        OP_RETURN: begin
`ifdef JUMP_TARGET_RAS_EN
          if (count_q == {CNT_W{1'b0}}) begin
            target_d = {ADDR_W{1'b0}};
            err_d    = 1'b1;
          end else begin
            target_d = ras_q[wp_q - PTR_W'(1)];
            err_d    = 1'b0;
            wp_d     = wp_q - PTR_W'(1);
            count_d  = count_q - CNT_W'(1);
          end
`else
          target_d = bus.pc_plus4;
          err_d    = 1'b1;
`endif
        end
        default: begin
          target_d = target_q;
          err_d    = err_q;
        end
      endcase
    end else if (bus.out_ready) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // Result register and handshake state, cleared by asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q  <= 1'b0;
      target_q <= {ADDR_W{1'b0}};
      err_q    <= 1'b0;
    end else begin
      valid_q  <= valid_d;
      target_q <= target_d;
      err_q    <= err_d;
    end
  end

`ifdef JUMP_TARGET_RAS_EN
  // Stack pointer and occupancy; reset empties the stack immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q    <= {PTR_W{1'b0}};
      count_q <= {CNT_W{1'b0}};
    end else begin
      wp_q    <= wp_d;
      count_q <= count_d;
    end
  end

  // Stack storage; contents are meaningless until pushed, so no reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      ras_q[wp_q] <= bus.pc_plus4;
    end
  end
`endif

endmodule

// File: tb/tb_jump_target_unit.sv
// Directed bench for jump_target_unit; expectations follow the build's
// JUMP_TARGET_RAS_EN setting.
module tb_jump_target_unit;

  localparam int ADDR_W    = 32;
  localparam int IDX_W     = 26;
  localparam int OFF_W     = 16;
  localparam int SHIFT     = 2;
  localparam int RAS_DEPTH = 4;
  localparam int CNT_W     = $clog2(RAS_DEPTH) + 1;

`ifdef JUMP_TARGET_RAS_EN
  localparam bit RAS_ON = 1'b1;
`else
  localparam bit RAS_ON = 1'b0;
`endif

  localparam logic [1:0] OP_JUMP   = 2'b00;
  localparam logic [1:0] OP_BRANCH = 2'b01;
  localparam logic [1:0] OP_CALL   = 2'b10;
  localparam logic [1:0] OP_RETURN = 2'b11;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  jump_target_if #(.ADDR_W(ADDR_W), .IDX_W(IDX_W), .RAS_DEPTH(RAS_DEPTH)) bus ();

  jump_target_unit #(
    .ADDR_W(ADDR_W), .IDX_W(IDX_W), .OFF_W(OFF_W), .SHIFT(SHIFT), .RAS_DEPTH(RAS_DEPTH)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Present one request with out_ready high; returns 1 time unit after the edge.
  task automatic issue(input logic [1:0] op, input logic [31:0] pc, input logic [25:0] imm);
    bus.op        = op;
    bus.pc_plus4  = pc;
    bus.imm       = imm;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.op = 2'b00;
    bus.pc_plus4 = 32'h0; bus.imm = 26'h0;
    #12;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", bus.out_valid); end
    checks++; if (bus.target !== 32'h0) begin errors++; $display("FAIL reset_target got %h exp 00000000", bus.target); end
    checks++; if (bus.out_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", bus.out_err); end
    checks++; if (bus.ras_count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", bus.ras_count); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", bus.in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_jump();
    issue(OP_JUMP, 32'h00400004, 26'h0100010);
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL jump_valid got %b exp 1", bus.out_valid); end
    checks++; if (bus.target !== 32'h00400040) begin errors++; $display("FAIL jump_target got %h exp 00400040", bus.target); end
    checks++; if (bus.out_err !== 1'b0) begin errors++; $display("FAIL jump_err got %b exp 0", bus.out_err); end
    issue(OP_JUMP, 32'hA0000000, 26'h3FFFFFF);
    checks++; if (bus.target !== 32'hAFFFFFFC) begin errors++; $display("FAIL jump_upper got %h exp affffffc", bus.target); end
  endtask

  task automatic test_branch();
    issue(OP_BRANCH, 32'h00400010, 26'h000FFFF);
    checks++; if (bus.target !== 32'h0040000C) begin errors++; $display("FAIL branch_neg got %h exp 0040000c", bus.target); end
    issue(OP_BRANCH, 32'hFFFFFFFC, 26'h0000002);
    checks++; if (bus.target !== 32'h00000004) begin errors++; $display("FAIL branch_wrap got %h exp 00000004", bus.target); end
    issue(OP_BRANCH, 32'h00001000, 26'h0007FFF);
    checks++; if (bus.target !== 32'h00020FFC) begin errors++; $display("FAIL branch_pos got %h exp 00020ffc", bus.target); end
    issue(OP_BRANCH, 32'h00002000, 26'h3FF0001);
    checks++; if (bus.target !== 32'h00002004) begin errors++; $display("FAIL branch_hi_imm got %h exp 00002004", bus.target); end
  endtask

  task automatic test_call_return();
    logic [31:0] exp_t;
    issue(OP_CALL, 32'h00400020, 26'h0100100);
    checks++; if (bus.target !== 32'h00400400) begin errors++; $display("FAIL call_target got %h exp 00400400", bus.target); end
    checks++; if (bus.ras_count !== (RAS_ON ? 3'd1 : 3'd0)) begin errors++; $display("FAIL call_count got %0d exp %0d", bus.ras_count, RAS_ON ? 1 : 0); end
    issue(OP_RETURN, 32'h00400024, 26'h0);
    exp_t = RAS_ON ? 32'h00400020 : 32'h00400024;
    checks++; if (bus.target !== exp_t) begin errors++; $display("FAIL ret_target got %h exp %h", bus.target, exp_t); end
    checks++; if (bus.out_err !== !RAS_ON) begin errors++; $display("FAIL ret_err got %b exp %b", bus.out_err, !RAS_ON); end
    checks++; if (bus.ras_count !== 3'd0) begin errors++; $display("FAIL ret_count got %0d exp 0", bus.ras_count); end
  endtask

  task automatic test_overflow();
    logic [31:0]      exp_t;
    logic [CNT_W-1:0] exp_c;
    for (int i = 0; i < 5; i++) begin
      issue(OP_CALL, 32'(32'h10 * (i + 1)), 26'h0);
      exp_c = RAS_ON ? CNT_W'((i + 1 > 4) ? 4 : i + 1) : 3'd0;
      checks++; if (bus.ras_count !== exp_c) begin errors++; $display("FAIL ovf_count%0d got %0d exp %0d", i, bus.ras_count, exp_c); end
    end
    for (int i = 0; i < 4; i++) begin
      issue(OP_RETURN, 32'(32'h900 + 4 * i), 26'h0);
      exp_t = RAS_ON ? 32'(32'h50 - 16 * i) : 32'(32'h900 + 4 * i);
      checks++; if (bus.target !== exp_t) begin errors++; $display("FAIL ovf_ret%0d got %h exp %h", i, bus.target, exp_t); end
      checks++; if (bus.out_err !== !RAS_ON) begin errors++; $display("FAIL ovf_err%0d got %b exp %b", i, bus.out_err, !RAS_ON); end
    end
    issue(OP_RETURN, 32'h00000A00, 26'h0);
    exp_t = RAS_ON ? 32'h0 : 32'h00000A00;
    checks++; if (bus.target !== exp_t) begin errors++; $display("FAIL empty_ret got %h exp %h", bus.target, exp_t); end
    checks++; if (bus.out_err !== 1'b1) begin errors++; $display("FAIL empty_err got %b exp 1", bus.out_err); end
    checks++; if (bus.ras_count !== 3'd0) begin errors++; $display("FAIL empty_count got %0d exp 0", bus.ras_count); end
    issue(OP_JUMP, 32'h00400004, 26'h0100010);
    checks++; if (bus.out_err !== 1'b0) begin errors++; $display("FAIL err_clear got %b exp 0", bus.out_err); end
  endtask

  task automatic test_backpressure();
    logic [CNT_W-1:0] exp_c;
    issue(OP_CALL, 32'h00000060, 26'h0000010);
    exp_c = RAS_ON ? 3'd1 : 3'd0;
    bus.out_ready = 1'b0;
    bus.op = OP_CALL; bus.pc_plus4 = 32'h00000070; bus.imm = 26'h0000020;
    bus.in_valid = 1'b1;
    #1;
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready got %b exp 0", bus.in_ready); end
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.target !== 32'h00000040) begin errors++; $display("FAIL bp_hold_target got %h exp 00000040", bus.target); end
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid got %b exp 1", bus.out_valid); end
    checks++; if (bus.ras_count !== exp_c) begin errors++; $display("FAIL bp_hold_count got %0d exp %0d", bus.ras_count, exp_c); end
    bus.out_ready = 1'b1;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got %b exp 1", bus.in_ready); end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    exp_c = RAS_ON ? 3'd2 : 3'd0;
    checks++; if (bus.target !== 32'h00000080) begin errors++; $display("FAIL bp_accept_target got %h exp 00000080", bus.target); end
    checks++; if (bus.ras_count !== exp_c) begin errors++; $display("FAIL bp_accept_count got %0d exp %0d", bus.ras_count, exp_c); end
    @(posedge clk);
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL drain_valid got %b exp 0", bus.out_valid); end
  endtask

  task automatic test_async_reset();
    logic [31:0] exp_t;
    issue(OP_CALL, 32'h00000080, 26'h0000030);
    checks++; if (bus.ras_count !== (RAS_ON ? 3'd3 : 3'd0)) begin errors++; $display("FAIL pre_rst_count got %0d exp %0d", bus.ras_count, RAS_ON ? 3 : 0); end
    bus.out_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL arst_valid got %b exp 0", bus.out_valid); end
    checks++; if (bus.ras_count !== 3'd0) begin errors++; $display("FAIL arst_count got %0d exp 0", bus.ras_count); end
    checks++; if (bus.target !== 32'h0) begin errors++; $display("FAIL arst_target got %h exp 00000000", bus.target); end
    @(negedge clk);
    rst_n = 1'b1;
    issue(OP_RETURN, 32'h00000B00, 26'h0);
    exp_t = RAS_ON ? 32'h0 : 32'h00000B00;
    checks++; if (bus.target !== exp_t) begin errors++; $display("FAIL post_rst_ret got %h exp %h", bus.target, exp_t); end
    checks++; if (bus.out_err !== 1'b1) begin errors++; $display("FAIL post_rst_err got %b exp 1", bus.out_err); end
  endtask

  initial begin
    test_reset();
    test_jump();
    test_branch();
    test_call_return();
    test_overflow();
    test_backpressure();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/jump_target_unit.md
# jump_target_unit

- Pipelined next-PC target generator for the MIPS fetch path.
- Computes one of three targets and registers it behind a valid/ready handshake:
  - J-type jump target: upper PC bits concatenated with index << SHIFT.
  - Branch target: PC+4 plus sign-extended offset << SHIFT.
  - Return target, popped from an internal return-address stack (RAS).
- Sits between decode and the PC mux. Replaces the fixed 26→28 shift-left wiring with a parametrised, stateful unit.

## Interface

Parameters:
- ADDR_W, 32, PC/address width.
- IDX_W, 26, jump index width. Must satisfy ADDR_W ≥ IDX_W+SHIFT.
- OFF_W, 16, branch offset width; taken from imm[OFF_W-1:0].
- SHIFT, 2, left-shift applied to index and offset.
- RAS_DEPTH, 4, return-address stack entries (power of two, ≥2).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  unit can accept a request this cycle.
- op  in  2  00 JUMP, 01 BRANCH, 10 CALL, 11 RETURN.
- pc_plus4  in  ADDR_W  PC+4 of the requesting instruction.
- imm  in  IDX_W  jump index, or branch offset in its low OFF_W bits.
- out_valid  out  1  target register holds a result.
- out_ready  in  1  consumer takes the result.
- target  out  ADDR_W  computed target address.
- out_err  out  1  the RETURN in the target register popped an empty stack.
- ras_count  out  $clog2(RAS_DEPTH)+1  current stack occupancy.

## Operation

- Accept when in_valid && in_ready. Result is written to the target register on the same edge.
- JUMP: target = {pc_plus4[ADDR_W-1:IDX_W+SHIFT], imm, SHIFT'b0}. If ADDR_W == IDX_W+SHIFT, there is no upper field.
- BRANCH: target = pc_plus4 + (sext(imm[OFF_W-1:0]) << SHIFT), modulo 2^ADDR_W (wraps, no flag).
- CALL: target is computed as for JUMP; pc_plus4 is pushed onto the RAS.
- RETURN, stack non-empty: target = top entry; the entry is popped.
- RETURN, stack empty: target = 0, out_err = 1, stack unchanged.
- RAS is circular: write pointer wp, count saturates at RAS_DEPTH.
  - Push when full overwrites the oldest entry; count stays RAS_DEPTH.
  - Pop decrements wp and count.
- Stack updates only on acceptance, never while a request is stalled.
- out_err is cleared by any non-erroring accepted op.

## Timing

- Latency 1: request accepted at edge N → out_valid=1 and target valid after edge N.
- in_ready = !out_valid || out_ready. Combinational from out_ready; no bubble on back-to-back traffic.
- With out_valid=1 and out_ready=0, target and out_err hold stable and in_ready=0.
- out_valid falls after the edge where out_ready=1 with no new acceptance.
- A CALL followed immediately by a RETURN (consecutive cycles) returns the just-pushed value; stack state is registered, so no forwarding hazard exists.
- Reset values: out_valid=0, target=0, out_err=0, ras_count=0, wp=0; RAS contents are don't-care.
- Reset asserted mid-operation discards the held result and empties the stack immediately, independent of clk.

## Configuration

- JUMP_TARGET_RAS_EN defined:
  - RAS, ras_count and out_err behave as above.
- JUMP_TARGET_RAS_EN undefined:
  - No stack storage is built; ras_count is tied to 0.
  - CALL behaves exactly as JUMP.
  - RETURN gives target = pc_plus4 with out_err = 1.

## Test plan

- JUMP: pc_plus4=0x00400004, imm=0x0100010 → target=0x00400040 one cycle later, out_err=0.
- BRANCH: pc_plus4=0x00400010, imm[15:0]=0xFFFF → target=0x0040000C. With pc_plus4=0xFFFFFFFC, offset 0x0002 → target=0x00000004 (wrap).
- CALL/RETURN: CALL with pc_plus4=0x00400020, imm=0x0100100 → target=0x00400400, ras_count=1. Next-cycle RETURN → target=0x00400020, ras_count=0.
- Overflow: 5 CALLs with pc_plus4 = 0x10, 0x20, 0x30, 0x40, 0x50 (RAS_DEPTH=4).
  - ras_count=4 after the CALLs.
  - 4 RETURNs give 0x50, 0x40, 0x30, 0x20.
  - 5th RETURN gives target=0, out_err=1.
- Backpressure: hold out_ready=0 with a result pending and present a CALL.
  - in_ready=0, target unchanged, ras_count unchanged.
  - Raise out_ready → the CALL is accepted on that edge.
- Async reset: drop rst_n mid-cycle with out_valid=1, ras_count=3 → out_valid=0, ras_count=0 before the next clk edge.
